// File: rtl/router_fsm.sv
// router_fsm
//   Packet router controller. It decodes the 2-bit destination address in
//   the header byte and then steps the datapath through header load,
//   payload load, full-FIFO stall, parity load and parity check. A stuck
//   output FIFO (its soft_reset) abandons the packet in progress.
//
// Ports
//   clock, reset          : rising-edge clock, async active-high reset
//   pkt_valid, data_in    : packet byte valid, header address bits [1:0]
//   fifo_full             : selected output FIFO is full
//   fifo_empty_0/1/2      : output FIFO n is empty
//   soft_reset_0/1/2      : output FIFO n timed out
//   parity_done           : parity byte already written
//   low_pkt_valid         : pkt_valid dropped while the FIFO was full
//   detect_add .. busy    : Moore state decodes for datapath and source
module router_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    FFS = 3'd3,
    LAF = 3'd4,
    LP  = 3'd5,
    CPE = 3'd6,
    WTE = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;

  // Padded to four entries so address 3 indexes a constant 0 instead of
  // falling off the end of the vector.
  logic [3:0] empty_vec;
  logic [3:0] soft_vec;

  assign empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DA;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      DA: begin
        // Address 3 is not a real port: the header is ignored and the
        // packet is dropped while we keep waiting for a valid one.
        if (pkt_valid && (data_in != 2'd3)) begin
          addr_d  = data_in;
          state_d = empty_vec[data_in] ? LFD : WTE;
        end
      end
      LFD: state_d = LD;
      LD: begin
        if (fifo_full)       state_d = FFS;
        else if (!pkt_valid) state_d = LP;
      end
      FFS: begin
        if (!fifo_full) state_d = LAF;
      end
      LAF: begin
        if (parity_done)        state_d = DA;
        else if (low_pkt_valid) state_d = LP;
        else                    state_d = LD;
      end
      LP:  state_d = CPE;
      CPE: state_d = fifo_full ? FFS : DA;
      WTE: begin
        if (empty_vec[addr_q]) state_d = LFD;
      end
      default: state_d = DA;
    endcase

    // Only the FIFO this packet is headed for can abandon it; DA has no
    // packet in flight so it is exempt.
    if ((state_q != DA) && soft_vec[addr_q]) state_d = DA;
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b0;
    case (state_q)
      DA:  detect_add = 1'b1;
      LFD: begin
        lfd_state = 1'b1;
        busy      = 1'b1;
      end
      LD: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
      end
      FFS: begin
        full_state = 1'b1;
        busy       = 1'b1;
      end
      LAF: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      LP: begin
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      CPE: begin
        rst_int_reg = 1'b1;
        busy        = 1'b1;
      end
      WTE: busy = 1'b1;
      default: detect_add = 1'b1;
    endcase
  end

endmodule
